// File: rtl/max7219_cmd_queue_if.sv
// Command-side and SPI-engine-side handshake bundle for the MAX7219 command queue.
// The queue takes the slave view; the sequencer/engine environment takes the master view.
interface max7219_cmd_queue_if;
    logic        cmd_valid;
    logic [15:0] cmd_word;
    logic        cmd_ready;
    logic        spi_start;
    logic [7:0]  spi_data;
    logic        spi_busy;

    modport master (
        output cmd_valid, cmd_word, spi_busy,
        input  cmd_ready, spi_start, spi_data
    );

    modport slave (
        input  cmd_valid, cmd_word, spi_busy,
        output cmd_ready, spi_start, spi_data
    );
endinterface

// File: rtl/max7219_cmd_queue.sv
// Buffers 16-bit MAX7219 register writes and feeds them to the SPI byte engine
// as two framed byte transfers, raising LOAD after each complete command.
module max7219_cmd_queue #(
    parameter int DEPTH     = 8,
    parameter int LOAD_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    max7219_cmd_queue_if.slave         bus,
    output logic                       max_load,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = $clog2(LOAD_HOLD + 1);

    typedef enum logic [2:0] {
        IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, LOAD
    } state_t;

    state_t          state;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      cur_lo;
    logic [HW-1:0]   hold;
    logic            push, pop;

    assign bus.cmd_ready = (fifo_count != CW'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == IDLE) && (fifo_count != '0);
    assign idle          = (state == IDLE) && (fifo_count == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.cmd_word;
    end

    // Pointers wrap on their own since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
        end
    end

    // spi_start/spi_data are loaded on entry to SEND_* so they are valid
    // during the SEND cycle itself; busy seen during SEND is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cur_lo        <= '0;
            hold          <= '0;
            max_load      <= 1'b1;
            bus.spi_start <= 1'b0;
            bus.spi_data  <= '0;
        end else begin
            bus.spi_start <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    cur_lo        <= mem[rd_ptr][7:0];
                    bus.spi_data  <= mem[rd_ptr][15:8];
                    bus.spi_start <= 1'b1;
                    max_load      <= 1'b0;
                    state         <= SEND_HI;
                end
                SEND_HI: state <= WAIT_HI;
                WAIT_HI: if (!bus.spi_busy) begin
                    bus.spi_data  <= cur_lo;
                    bus.spi_start <= 1'b1;
                    state         <= SEND_LO;
                end
                SEND_LO: state <= WAIT_LO;
                WAIT_LO: if (!bus.spi_busy) begin
                    max_load <= 1'b1;
                    hold     <= HW'(LOAD_HOLD - 1);
                    state    <= LOAD;
                end
                LOAD: begin
                    if (hold == '0) state <= IDLE;
                    else            hold  <= hold - HW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_max7219_cmd_queue.sv
// Directed bench for max7219_cmd_queue: table of single commands plus hand-written
// sequences for fill/drain, push-on-pop, framing and mid-word reset.
module tb_max7219_cmd_queue;
    localparam int DEPTH     = 8;
    localparam int LOAD_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       max_load;
    logic [3:0] fifo_count;
    logic       idle;

    max7219_cmd_queue_if bus ();

    max7219_cmd_queue #(.DEPTH(DEPTH), .LOAD_HOLD(LOAD_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .max_load   (max_load),
        .fifo_count (fifo_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // Engine model: busy rises combinationally with start, lasts busy_len cycles.
    int   busy_len   = 2;
    logic force_busy = 1'b0;
    int   busy_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst)                busy_cnt <= 0;
        else if (bus.spi_start) busy_cnt <= busy_len - 1;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.spi_busy = force_busy | bus.spi_start | (busy_cnt != 0);

    // Protocol monitor: collects bytes and counts framing violations.
    logic [7:0] bytes [$];
    logic [7:0] last_data;
    logic       prev_start, prev_load;
    int         starts_in_frame, high_len, frames = 0, prot_err = 0;
    bit         seen_frame;

    always @(negedge clk) begin
        if (rst) begin
            prev_start      = 1'b0;
            prev_load       = 1'b1;
            starts_in_frame = 0;
            high_len        = 0;
            seen_frame      = 0;
            last_data       = '0;
        end else begin
            if (prev_load && !max_load) begin
                if (seen_frame && high_len < LOAD_HOLD + 1) prot_err++;
                starts_in_frame = 0;
            end
            if (bus.spi_start) begin
                bytes.push_back(bus.spi_data);
                last_data = bus.spi_data;
                starts_in_frame++;
                if (max_load || prev_start) prot_err++;
            end else if (bus.spi_busy && bus.spi_data != last_data) begin
                prot_err++;
            end
            if (!prev_load && max_load) begin
                if (starts_in_frame != 2) prot_err++;
                frames++;
                seen_frame = 1;
                high_len   = 0;
            end
            if (max_load) high_len++;
            prev_start = bus.spi_start;
            prev_load  = max_load;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) check("push_ready_timeout", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_word  = w;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int n = 0;
        @(negedge clk);
        while (!idle && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(idle), 32'd1);
    endtask

    typedef struct {
        logic [15:0] word;
        int          busy;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int f0;
        vecs[0] = '{16'h0C01, 20, 8'h0C, 8'h01};
        vecs[1] = '{16'h0F00,  2, 8'h0F, 8'h00};
        vecs[2] = '{16'h0900,  1, 8'h09, 8'h00};
        vecs[3] = '{16'h0AFF,  3, 8'h0A, 8'hFF};
        vecs[4] = '{16'h0B07,  1, 8'h0B, 8'h07};

        bus.cmd_valid = 1'b0;
        bus.cmd_word  = '0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready",  32'(bus.cmd_ready), 32'd1);
        check("rst_spi_start",  32'(bus.spi_start), 32'd0);
        check("rst_spi_data",   32'(bus.spi_data),  32'd0);
        check("rst_max_load",   32'(max_load),      32'd1);
        check("rst_fifo_count", 32'(fifo_count),    32'd0);
        check("rst_idle",       32'(idle),          32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single command with exact LOAD timing and a slow engine.
        busy_len = 20;
        bytes.delete();
        push(16'h0C01);
        @(negedge clk);
        check("single_queued_load", 32'(max_load),   32'd1);
        check("single_queued_cnt",  32'(fifo_count), 32'd1);
        @(negedge clk);
        check("single_pop_load",  32'(max_load),      32'd0);
        check("single_pop_start", 32'(bus.spi_start), 32'd1);
        check("single_pop_data",  32'(bus.spi_data),  32'h0C);
        check("single_pop_cnt",   32'(fifo_count),    32'd0);
        n = 0;
        while (!max_load && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("single_load_rise", 32'(max_load), 32'd1);
        n = 0;
        while (!idle && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("single_load_hold", 32'(n), 32'(LOAD_HOLD));
        check("single_nbytes", 32'(bytes.size()), 32'd2);
        check("single_b0", 32'(bytes[0]), 32'h0C);
        check("single_b1", 32'(bytes[1]), 32'h01);

        for (int i = 0; i < 5; i++) begin
            busy_len = vecs[i].busy;
            bytes.delete();
            f0 = frames;
            push(vecs[i].word);
            wait_idle(200, $sformatf("vec%0d_idle", i));
            check($sformatf("vec%0d_nbytes", i), 32'(bytes.size()), 32'd2);
            check($sformatf("vec%0d_hi", i), 32'(bytes[0]), 32'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 32'(bytes[1]), 32'(vecs[i].lo));
            check($sformatf("vec%0d_frames", i), 32'(frames - f0), 32'd1);
            check($sformatf("vec%0d_load", i), 32'(max_load), 32'd1);
        end

        // Fill behind a stalled engine, try one push while full, then drain.
        busy_len = 2;
        bytes.delete();
        @(negedge clk);
        force_busy = 1'b1;
        for (int k = 0; k < 9; k++) push(16'h0100 + 16'(k));
        @(negedge clk);
        check("fill_count", 32'(fifo_count),    32'd8);
        check("fill_ready", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_word  = 16'h01FF;
        repeat (3) @(negedge clk);
        check("fill_no_overwrite", 32'(fifo_count), 32'd8);
        bus.cmd_valid = 1'b0;
        force_busy = 1'b0;
        wait_idle(2000, "drain_idle");
        check("drain_nbytes", 32'(bytes.size()), 32'd18);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("drain_hi%0d", k), 32'(bytes[2*k]),   32'h01);
            check($sformatf("drain_lo%0d", k), 32'(bytes[2*k+1]), 32'(k));
        end

        // Second push lands on the pop cycle of the first.
        bytes.delete();
        push(16'h0301);
        push(16'h0402);
        @(negedge clk);
        check("pushpop_count", 32'(fifo_count),   32'd1);
        check("pushpop_data",  32'(bus.spi_data), 32'h03);
        wait_idle(200, "pushpop_idle");
        check("pushpop_nbytes", 32'(bytes.size()), 32'd4);
        check("pushpop_b0", 32'(bytes[0]), 32'h03);
        check("pushpop_b1", 32'(bytes[1]), 32'h01);
        check("pushpop_b2", 32'(bytes[2]), 32'h04);
        check("pushpop_b3", 32'(bytes[3]), 32'h02);

        // Back-to-back framing.
        bytes.delete();
        f0 = frames;
        push(16'h0501);
        push(16'h0602);
        push(16'h0703);
        wait_idle(300, "b2b_idle");
        check("b2b_frames", 32'(frames - f0),   32'd3);
        check("b2b_nbytes", 32'(bytes.size()), 32'd6);
        check("b2b_b0", 32'(bytes[0]), 32'h05);
        check("b2b_b3", 32'(bytes[3]), 32'h02);
        check("b2b_b5", 32'(bytes[5]), 32'h03);
        check("b2b_protocol", 32'(prot_err), 32'd0);

        // Reset while waiting on the low byte with three commands queued.
        busy_len = 1;
        @(negedge clk);
        force_busy = 1'b1;
        push(16'h0111);
        push(16'h0222);
        push(16'h0333);
        push(16'h0444);
        @(negedge clk);
        force_busy = 1'b0;
        @(negedge clk);
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_pre_data", 32'(bus.spi_data), 32'h11);
        check("midrst_pre_load", 32'(max_load),     32'd0);
        check("midrst_pre_cnt",  32'(fifo_count),   32'd3);
        #2 rst = 1'b1;
        #1;
        check("midrst_load",  32'(max_load),      32'd1);
        check("midrst_start", 32'(bus.spi_start), 32'd0);
        check("midrst_cnt",   32'(fifo_count),    32'd0);
        check("midrst_ready", 32'(bus.cmd_ready), 32'd1);
        force_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bytes.delete();
        repeat (20) @(negedge clk);
        check("postrst_silent", 32'(bytes.size()), 32'd0);
        check("postrst_idle",   32'(idle),         32'd1);
        push(16'h0C01);
        wait_idle(200, "postrst_cmd_idle");
        check("postrst_nbytes", 32'(bytes.size()), 32'd2);
        check("postrst_b0", 32'(bytes[0]), 32'h0C);
        check("postrst_b1", 32'(bytes[1]), 32'h01);

        check("protocol", 32'(prot_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
